// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Fetch-side bus between the next-PC sequencer and the rest of the pipeline.
//
// Signals:
//   pc_cur        current PC, read back from the PC register
//   pc_next       next PC, driven to the PC register input
//   pc_write_en   PC register load enable
//   hazard_stall  load-use stall from the hazard unit
//   imem_ready    instruction memory can accept a fetch this cycle
//   br_taken      EX-stage branch resolved taken
//   br_target     branch target
//   jmp           ID-stage jump
//   jmp_target    jump target
//   if_id_flush   squash the IF/ID register this cycle
//
// Modports:
//   master  the sequencer (drives pc_next, pc_write_en, if_id_flush)
//   slave   the pipeline / PC register side
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_write_en;
    logic        hazard_stall;
    logic        imem_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        if_id_flush;

    modport master (
        input  pc_cur,
        input  hazard_stall,
        input  imem_ready,
        input  br_taken,
        input  br_target,
        input  jmp,
        input  jmp_target,
        output pc_next,
        output pc_write_en,
        output if_id_flush
    );

    modport slave (
        output pc_cur,
        output hazard_stall,
        output imem_ready,
        output br_taken,
        output br_target,
        output jmp,
        output jmp_target,
        input  pc_next,
        input  pc_write_en,
        input  if_id_flush
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Next-PC controller for the fetch stage of a 5-stage MIPS pipeline.
// Chooses between sequential fetch, EX branch redirect, ID jump redirect,
// hazard stall and instruction-memory wait. A redirect that arrives while
// the memory is busy is parked in pend_target until the fetch can go out.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   bus             pc_sequencer_if.master (PC register + redirect sources)
//   redirect_count  number of redirects applied, saturating
//   stall_timeout   sticky flag: PC has not advanced for STALL_LIMIT cycles
//
// States:
//   state      | meaning
//   -----------+------------------------------------------------------------
//   BOOT       | single cycle after reset; load RESET_VECTOR, flush IF/ID
//   RUN        | normal fetch: redirect > stall/wait > PC+4
//   REDIR_HOLD | redirect accepted but imem busy; hold target, keep flushing
//
// pc_next / pc_write_en / if_id_flush are combinational so the PC register
// loads on the same edge the decision is made.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16,
    parameter int          STALL_LIMIT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    pc_sequencer_if.master   bus,
    output logic [CNT_W-1:0] redirect_count,
    output logic             stall_timeout
);

    localparam int              SC_W      = $clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_LIMIT);
    localparam logic [SC_W-1:0] STALL_PRE = SC_W'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [31:0]     pend_target;
    logic [31:0]     pend_d;
    logic [SC_W-1:0] stall_cnt;

    logic        redir_req;
    logic [31:0] redir_tgt;
    logic [31:0] hold_tgt;
    logic [31:0] pc_sel;
    logic        write_en;
    logic        flush;
    logic        apply_redir;

    // Branch is the older instruction, so it wins over a simultaneous jump.
    assign redir_req = bus.br_taken | bus.jmp;
    assign redir_tgt = bus.br_taken ? bus.br_target : bus.jmp_target;
    // In hold, a fresh redirect replaces the parked one.
    assign hold_tgt  = redir_req ? redir_tgt : pend_target;

    always_comb begin
        state_d     = state;
        pend_d      = pend_target;
        pc_sel      = bus.pc_cur;
        write_en    = 1'b0;
        flush       = 1'b0;
        apply_redir = 1'b0;

        case (state)
            BOOT: begin
                pc_sel   = RESET_VECTOR;
                write_en = 1'b1;
                flush    = 1'b1;
                state_d  = RUN;
            end

            RUN: begin
                if (redir_req) begin
                    flush = 1'b1;
                    if (bus.imem_ready) begin
                        pc_sel      = redir_tgt;
                        write_en    = 1'b1;
                        apply_redir = 1'b1;
                    end else begin
                        pend_d  = redir_tgt;
                        state_d = REDIR_HOLD;
                    end
                end else if (bus.hazard_stall || !bus.imem_ready) begin
                    pc_sel = bus.pc_cur;
                end else begin
                    pc_sel   = bus.pc_cur + 32'd4;
                    write_en = 1'b1;
                end
            end

            REDIR_HOLD: begin
                // Pipeline is already squashed, so hazard_stall has no say.
                flush  = 1'b1;
                pend_d = hold_tgt;
                if (bus.imem_ready) begin
                    pc_sel      = hold_tgt;
                    write_en    = 1'b1;
                    apply_redir = 1'b1;
                    state_d     = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        // Outputs follow reset immediately, not at the next edge.
        if (!reset) begin
            pc_sel      = RESET_VECTOR;
            write_en    = 1'b0;
            flush       = 1'b1;
            apply_redir = 1'b0;
        end
    end

    // Word alignment is enforced on every source, including targets.
    assign bus.pc_next     = {pc_sel[31:2], 2'b00};
    assign bus.pc_write_en = write_en;
    assign bus.if_id_flush = flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= BOOT;
            pend_target    <= 32'h0000_0000;
            redirect_count <= '0;
            stall_cnt      <= '0;
            stall_timeout  <= 1'b0;
        end else begin
            state       <= state_d;
            pend_target <= pend_d;

            if (apply_redir && (redirect_count != {CNT_W{1'b1}})) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end

            // Watchdog counts consecutive cycles where the PC holds still.
            if (write_en) begin
                stall_cnt <= '0;
            end else if (state != BOOT) begin
                if (stall_cnt != STALL_MAX) begin
                    stall_cnt <= stall_cnt + SC_W'(1);
                end
                if (stall_cnt >= STALL_PRE) begin
                    stall_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic [15:0] redirect_count;
    logic        stall_timeout;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .CNT_W        (16),
        .STALL_LIMIT  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.master),
        .redirect_count (redirect_count),
        .stall_timeout  (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic        fl;
        logic        chk_pc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Scoreboard consumer: expectation for a cycle is compared mid low phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_pc) begin
                    n_checks++;
                    if (bus.pc_next !== e.pc) begin
                        n_fail++;
                        $display("FAIL %s pc_next got %h want %h", e.name, bus.pc_next, e.pc);
                    end
                end
                n_checks++;
                if (bus.pc_write_en !== e.we) begin
                    n_fail++;
                    $display("FAIL %s pc_write_en got %b want %b", e.name, bus.pc_write_en, e.we);
                end
                n_checks++;
                if (bus.if_id_flush !== e.fl) begin
                    n_fail++;
                    $display("FAIL %s if_id_flush got %b want %b", e.name, bus.if_id_flush, e.fl);
                end
            end
        end
    end

    // Drive one cycle of inputs at the negedge and queue the expected outputs.
    task automatic step(input logic [31:0] pc, input logic hs, input logic ir,
                        input logic bt, input logic [31:0] btg,
                        input logic j, input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic e_we, input logic e_fl,
                        input logic e_chk, input string name);
        exp_t e;
        bus.pc_cur       = pc;
        bus.hazard_stall = hs;
        bus.imem_ready   = ir;
        bus.br_taken     = bt;
        bus.br_target    = btg;
        bus.jmp          = j;
        bus.jmp_target   = jt;
        e.pc = e_pc; e.we = e_we; e.fl = e_fl; e.chk_pc = e_chk; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step_inputs_idle();
        #1;
        n_checks++;
        if (bus.pc_next !== RV) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc_next, RV); end
        n_checks++;
        if (bus.pc_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.pc_write_en); end
        n_checks++;
        if (bus.if_id_flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush got %b want 1", bus.if_id_flush); end
        n_checks++;
        if (redirect_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", redirect_count); end
        n_checks++;
        if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", stall_timeout); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step_inputs_idle();
        bus.pc_cur = 32'h0; bus.hazard_stall = 1'b0; bus.imem_ready = 1'b1;
        bus.br_taken = 1'b0; bus.br_target = 32'h0; bus.jmp = 1'b0; bus.jmp_target = 32'h0;
    endtask

    task automatic test_boot();
        step(32'h0,   0, 1, 0, 0, 0, 0, 32'h100, 1, 1, 1, "boot");
        step(32'h100, 0, 1, 0, 0, 0, 0, 32'h104, 1, 0, 1, "seq1");
        step(32'h104, 0, 1, 0, 0, 0, 0, 32'h108, 1, 0, 1, "seq2");
        n_checks++;
        if (redirect_count !== 16'd0) begin n_fail++; $display("FAIL boot_cnt got %0d want 0", redirect_count); end
    endtask

    task automatic test_redirect_priority();
        step(32'h20, 0, 1, 1, 32'h80, 1, 32'h40, 32'h80, 1, 1, 1, "br_over_jmp");
        n_checks++;
        if (redirect_count !== 16'd1) begin n_fail++; $display("FAIL prio_cnt got %0d want 1", redirect_count); end
        step(32'h80, 0, 1, 0, 0, 1, 32'h44, 32'h44, 1, 1, 1, "jmp_only");
        n_checks++;
        if (redirect_count !== 16'd2) begin n_fail++; $display("FAIL jmp_cnt got %0d want 2", redirect_count); end
    endtask

    task automatic test_redir_hold();
        step(32'h20, 0, 0, 0, 0, 1, 32'h200, 32'h0,   0, 1, 0, "hold_enter");
        step(32'h20, 0, 0, 0, 0, 0, 0,       32'h20,  0, 1, 1, "hold_wait1");
        step(32'h20, 0, 0, 0, 0, 0, 0,       32'h20,  0, 1, 1, "hold_wait2");
        step(32'h20, 0, 1, 0, 0, 0, 0,       32'h200, 1, 1, 1, "hold_release");
        n_checks++;
        if (redirect_count !== 16'd3) begin n_fail++; $display("FAIL hold_cnt got %0d want 3", redirect_count); end
        step(32'h200, 0, 1, 0, 0, 0, 0,      32'h204, 1, 0, 1, "hold_back_run");
        n_checks++;
        if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL hold_timeout got %b want 0", stall_timeout); end
    endtask

    task automatic test_stall();
        step(32'h40,  1, 1, 0, 0,       0, 0, 32'h40,  0, 0, 1, "stall1");
        step(32'h40,  1, 1, 0, 0,       0, 0, 32'h40,  0, 0, 1, "stall2");
        step(32'h40,  0, 1, 0, 0,       0, 0, 32'h44,  1, 0, 1, "stall_resume");
        step(32'h44,  1, 1, 1, 32'h300, 0, 0, 32'h300, 1, 1, 1, "stall_vs_branch");
        n_checks++;
        if (redirect_count !== 16'd4) begin n_fail++; $display("FAIL stall_cnt got %0d want 4", redirect_count); end
        step(32'h300, 0, 0, 0, 0,       0, 0, 32'h300, 0, 0, 1, "imem_wait");
    endtask

    task automatic test_hold_overwrite();
        step(32'h10,  0, 0, 0, 0,       1, 32'h400, 32'h0,   0, 1, 0, "ovr_enter");
        step(32'h10,  0, 0, 1, 32'h503, 0, 0,       32'h10,  0, 1, 1, "ovr_branch");
        step(32'h10,  1, 1, 0, 0,       0, 0,       32'h500, 1, 1, 1, "ovr_release_hs");
        n_checks++;
        if (redirect_count !== 16'd5) begin n_fail++; $display("FAIL ovr_cnt got %0d want 5", redirect_count); end
        step(32'h500, 0, 0, 0, 0,       1, 32'h600, 32'h0,   0, 1, 0, "ovr2_enter");
        step(32'h500, 0, 1, 0, 0,       1, 32'h704, 32'h704, 1, 1, 1, "ovr2_same_cycle");
        n_checks++;
        if (redirect_count !== 16'd6) begin n_fail++; $display("FAIL ovr2_cnt got %0d want 6", redirect_count); end
    endtask

    task automatic test_wrap_align();
        step(32'hFFFF_FFFC, 0, 1, 0, 0,      0, 0, 32'h0,  1, 0, 1, "wrap");
        step(32'h0,         0, 1, 1, 32'h83, 0, 0, 32'h80, 1, 1, 1, "align");
        n_checks++;
        if (redirect_count !== 16'd7) begin n_fail++; $display("FAIL align_cnt got %0d want 7", redirect_count); end
    endtask

    task automatic test_watchdog();
        for (int i = 1; i <= 5; i++) begin
            step(32'h50, 0, 0, 0, 0, 0, 0, 32'h50, 0, 0, 1, "wd_wait");
            n_checks++;
            if (stall_timeout !== (i >= 4)) begin
                n_fail++;
                $display("FAIL wd_cycle%0d timeout got %b want %b", i, stall_timeout, (i >= 4));
            end
        end
        step(32'h50, 0, 1, 0, 0, 0, 0, 32'h54, 1, 0, 1, "wd_resume");
        n_checks++;
        if (stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b want 1", stall_timeout); end
    endtask

    task automatic test_reset_mid_hold();
        step(32'h54, 0, 0, 0, 0, 1, 32'h600, 32'h0,  0, 1, 0, "mid_enter");
        step(32'h54, 0, 0, 0, 0, 0, 0,       32'h54, 0, 1, 1, "mid_wait");
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.pc_next !== RV) begin n_fail++; $display("FAIL mid_pc got %h want %h", bus.pc_next, RV); end
        n_checks++;
        if (bus.pc_write_en !== 1'b0) begin n_fail++; $display("FAIL mid_we got %b want 0", bus.pc_write_en); end
        n_checks++;
        if (bus.if_id_flush !== 1'b1) begin n_fail++; $display("FAIL mid_flush got %b want 1", bus.if_id_flush); end
        n_checks++;
        if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_timeout got %b want 0", stall_timeout); end
        n_checks++;
        if (redirect_count !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", redirect_count); end
        @(negedge clk);
        reset = 1'b1;
        step(32'h54,  0, 0, 0, 0, 0, 0, 32'h100, 1, 1, 1, "reboot_ignores_ready");
        step(32'h100, 0, 1, 0, 0, 0, 0, 32'h104, 1, 0, 1, "reboot_pending_dropped");
        n_checks++;
        if (redirect_count !== 16'd0) begin n_fail++; $display("FAIL reboot_cnt got %0d want 0", redirect_count); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_redirect_priority();
        test_redir_hold();
        test_stall();
        test_hold_overwrite();
        test_wrap_align();
        test_watchdog();
        test_reset_mid_hold();
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
